// File: rtl/audio_pkg.sv
// Shared definitions for the stereo echo effect.
//   SAMPLE_W / GAIN_W : sample and gain widths
//   state_t           : controller states (CLEAR, IDLE, READ, MAC, WRITE)
//   sat16             : clamp an 18-bit signed sum into the 16-bit sample range
package audio_pkg;

  localparam int SAMPLE_W = 16;
  localparam int GAIN_W   = 8;

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_READ,
    ST_MAC,
    ST_WRITE
  } state_t;

  // In range exactly when the three top bits agree (no magnitude beyond 16 bits).
  function automatic logic [SAMPLE_W-1:0] sat16(input logic [SAMPLE_W+1:0] v);
    logic [2:0] top;
    top = v[SAMPLE_W+1:SAMPLE_W-1];
    if (top == 3'b000 || top == 3'b111) begin
      sat16 = v[SAMPLE_W-1:0];
    end else if (v[SAMPLE_W+1]) begin
      sat16 = {1'b1, {(SAMPLE_W-1){1'b0}}};
    end else begin
      sat16 = {1'b0, {(SAMPLE_W-1){1'b1}}};
    end
  endfunction

endpackage

// File: rtl/echo_ram.sv
// Delay-line storage: simple dual-port RAM, 2**ADDR_W words of DATA_W bits.
//   clk            : clock
//   we/waddr/wdata : synchronous write port
//   raddr/rdata    : read port, data registered one cycle after the address
module echo_ram #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/audio_echo.sv
// Stereo feedback echo between an I2S receiver and transmitter.
//   clk, rst              : system clock, synchronous active-high reset
//   in_left/in_right      : signed input frame, valid on rising edge of in_rec_clk
//   delay                 : echo delay in frames (0 = full delay-line depth)
//   fb_gain / mix_gain    : Q0.8 feedback and wet gains
//   bypass                : pass input through, still recording it into the delay line
//   out_left/out_right    : processed frame, updated with a 1-cycle out_valid pulse
//   ready                 : idle with the delay line cleared
//   overrun               : sticky flag for frames dropped while busy
module audio_echo
  import audio_pkg::*;
#(
  parameter int ADDR_W = 11
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] in_left,
  input  logic [SAMPLE_W-1:0] in_right,
  input  logic                in_rec_clk,
  input  logic [ADDR_W-1:0]   delay,
  input  logic [GAIN_W-1:0]   fb_gain,
  input  logic [GAIN_W-1:0]   mix_gain,
  input  logic                bypass,
  output logic [SAMPLE_W-1:0] out_left,
  output logic [SAMPLE_W-1:0] out_right,
  output logic                out_valid,
  output logic                ready,
  output logic                overrun
);

  localparam int CH_L = 1;  // channel index 1 = left, matches {left, right} RAM packing
  localparam int CH_R = 0;

  state_t state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic              rec_q, rec_d;
  logic              out_valid_q, out_valid_d;
  logic              ready_q, ready_d;
  logic              overrun_q, overrun_d;
  logic [1:0][SAMPLE_W-1:0] out_q, out_d;

  // Per-frame captured controls and samples
  logic [1:0][SAMPLE_W-1:0] x_q, x_d;
  logic [ADDR_W-1:0]        dly_q, dly_d;
  logic [GAIN_W-1:0]        fb_q, fb_d, mix_q, mix_d;
  logic                     byp_q, byp_d;

  // Scaled delay-line products, 17 bits after the >>> 8
  logic [1:0][SAMPLE_W:0] pfb_q, pfb_d, pmix_q, pmix_d;

  logic [1:0][SAMPLE_W-1:0] rd_data, wr_calc, out_calc;
  logic                     ram_we;
  logic [ADDR_W-1:0]        ram_waddr, ram_raddr;
  logic [2*SAMPLE_W-1:0]    ram_wdata;
  logic                     rec_edge;

  echo_ram #(.ADDR_W(ADDR_W), .DATA_W(2 * SAMPLE_W)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (ram_raddr),
    .rdata (rd_data)
  );

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ch
      logic signed [SAMPLE_W+GAIN_W:0] prod_fb, prod_mix;
      logic        [SAMPLE_W+1:0]      sum_fb, sum_mix;

      // Both operands widened to the 25-bit product width; gain is zero-extended.
      assign prod_fb  = $signed({{(GAIN_W+1){rd_data[gi][SAMPLE_W-1]}}, rd_data[gi]})
                      * $signed({{(SAMPLE_W+1){1'b0}}, fb_q});
      assign prod_mix = $signed({{(GAIN_W+1){rd_data[gi][SAMPLE_W-1]}}, rd_data[gi]})
                      * $signed({{(SAMPLE_W+1){1'b0}}, mix_q});
      // Dropping the low 8 bits of a two's-complement value is a floor divide by 256.
      assign pfb_d[gi]  = prod_fb[SAMPLE_W+GAIN_W:GAIN_W];
      assign pmix_d[gi] = prod_mix[SAMPLE_W+GAIN_W:GAIN_W];

      assign sum_fb  = {{2{x_q[gi][SAMPLE_W-1]}}, x_q[gi]} + {pfb_q[gi][SAMPLE_W], pfb_q[gi]};
      assign sum_mix = {{2{x_q[gi][SAMPLE_W-1]}}, x_q[gi]} + {pmix_q[gi][SAMPLE_W], pmix_q[gi]};

      assign wr_calc[gi]  = byp_q ? x_q[gi] : sat16(sum_fb);
      assign out_calc[gi] = byp_q ? x_q[gi] : sat16(sum_mix);
    end
  endgenerate

  assign rec_edge = in_rec_clk & ~rec_q;

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    wr_ptr_d    = wr_ptr_q;
    rec_d       = in_rec_clk;
    out_d       = out_q;
    out_valid_d = 1'b0;
    overrun_d   = overrun_q;
    x_d         = x_q;
    dly_d       = dly_q;
    fb_d        = fb_q;
    mix_d       = mix_q;
    byp_d       = byp_q;
    ram_we      = 1'b0;
    ram_waddr   = wr_ptr_q;
    ram_wdata   = wr_calc;
    // Subtraction wraps mod depth; delay 0 reads the slot about to be overwritten.
    ram_raddr   = wr_ptr_q - dly_q;

    case (state_q)
      ST_CLEAR: begin
        ram_we    = 1'b1;
        ram_waddr = clr_cnt_q;
        ram_wdata = '0;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == '1) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (rec_edge) begin
          x_d     = {in_left, in_right};
          dly_d   = delay;
          fb_d    = fb_gain;
          mix_d   = mix_gain;
          byp_d   = bypass;
          state_d = ST_READ;
        end
      end
      ST_READ:  state_d = ST_MAC;
      ST_MAC:   state_d = ST_WRITE;
      ST_WRITE: begin
        ram_we      = 1'b1;
        wr_ptr_d    = wr_ptr_q + 1'b1;
        out_d       = out_calc;
        out_valid_d = 1'b1;
        state_d     = ST_IDLE;
      end
      default:  state_d = ST_CLEAR;
    endcase

    if (rec_edge && state_q != ST_CLEAR && state_q != ST_IDLE) begin
      overrun_d = 1'b1;
    end

    // A frame aborted by reset must leave the delay line untouched.
    if (rst) begin
      ram_we = 1'b0;
    end

    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_CLEAR;
      clr_cnt_q   <= '0;
      wr_ptr_q    <= '0;
      rec_q       <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      ready_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rec_q       <= rec_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      ready_q     <= ready_d;
      overrun_q   <= overrun_d;
    end
  end

  // Datapath registers only carry meaning inside a frame, so they need no reset.
  always_ff @(posedge clk) begin
    x_q    <= x_d;
    dly_q  <= dly_d;
    fb_q   <= fb_d;
    mix_q  <= mix_d;
    byp_q  <= byp_d;
    pfb_q  <= pfb_d;
    pmix_q <= pmix_d;
  end

  assign out_left  = out_q[CH_L];
  assign out_right = out_q[CH_R];
  assign out_valid = out_valid_q;
  assign ready     = ready_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_audio_echo.sv
// Self-checking bench for audio_echo with a 16-frame delay line.
module tb_audio_echo;

  localparam int AW    = 4;
  localparam int DEPTH = 2 ** AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [15:0]   in_left = '0, in_right = '0;
  logic          in_rec_clk = 1'b0;
  logic [AW-1:0] delay = '0;
  logic [7:0]    fb_gain = '0, mix_gain = '0;
  logic          bypass = 1'b0;
  logic [15:0]   out_left, out_right;
  logic          out_valid, ready, overrun;

  audio_echo #(.ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_left    (in_left),
    .in_right   (in_right),
    .in_rec_clk (in_rec_clk),
    .delay      (delay),
    .fb_gain    (fb_gain),
    .mix_gain   (mix_gain),
    .bypass     (bypass),
    .out_left   (out_left),
    .out_right  (out_right),
    .out_valid  (out_valid),
    .ready      (ready),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference delay line: one entry per frame slot, written in frame order.
  int m_l [DEPTH];
  int m_r [DEPTH];
  int m_wp;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic int scale(input int d, input int g);
    return (d * g) >>> 8;
  endfunction

  function automatic int rnd_sample();
    return int'($urandom_range(65535, 0)) - 32768;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      m_l[i] = 0;
      m_r[i] = 0;
    end
    m_wp = 0;
  endtask

  task automatic model_frame(input int xl, input int xr, input int dly, input int fb,
                             input int mix, input int byp, output int ol, output int orr);
    int rp, dl, dr;
    rp = (m_wp - dly) & (DEPTH - 1);
    dl = m_l[rp];
    dr = m_r[rp];
    if (byp != 0) begin
      ol = xl;
      orr = xr;
      m_l[m_wp] = xl;
      m_r[m_wp] = xr;
    end else begin
      ol  = sat(xl + scale(dl, mix));
      orr = sat(xr + scale(dr, mix));
      m_l[m_wp] = sat(xl + scale(dl, fb));
      m_r[m_wp] = sat(xr + scale(dr, fb));
    end
    m_wp = (m_wp + 1) % DEPTH;
  endtask

  // Called at a negedge just after rst was lowered; toggles in_rec_clk during CLEAR.
  task automatic wait_ready();
    int n;
    int saw_valid;
    n = 0;
    saw_valid = 0;
    for (int c = 1; c <= 4 * DEPTH; c++) begin
      in_rec_clk = ~in_rec_clk;
      @(posedge clk);
      #1;
      if (out_valid) saw_valid = 1;
      if (ready) begin
        n = c;
        break;
      end
      @(negedge clk);
    end
    chk("clear_cycles", n, DEPTH);
    chk("no_valid_in_clear", saw_valid, 0);
    @(negedge clk);
    in_rec_clk = 1'b0;
    @(posedge clk);
    #1;
    chk("overrun_after_clear", overrun, 0);
    model_clear();
  endtask

  task automatic check_reset_values();
    chk("rst_out_left", $signed(out_left), 0);
    chk("rst_out_right", $signed(out_right), 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_ready", ready, 0);
    chk("rst_overrun", overrun, 0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    in_rec_clk = 1'b0;
    @(posedge clk);
    #1;
    check_reset_values();
    @(negedge clk);
    rst = 1'b0;
    wait_ready();
  endtask

  // One frame: edge, scramble inputs after capture, check latency/values/pulse width.
  task automatic send_frame(input int xl, input int xr, input int dly, input int fb,
                            input int mix, input int byp, output int ol, output int orr);
    int el, er, lat;
    @(negedge clk);
    in_left    = 16'(xl);
    in_right   = 16'(xr);
    delay      = AW'(dly);
    fb_gain    = 8'(fb);
    mix_gain   = 8'(mix);
    bypass     = 1'(byp);
    in_rec_clk = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_rec_clk = 1'b0;
    in_left    = 16'($urandom);
    in_right   = 16'($urandom);
    delay      = AW'($urandom);
    fb_gain    = 8'($urandom);
    mix_gain   = 8'($urandom);
    bypass     = 1'($urandom);
    lat = 0;
    for (int c = 2; c <= 10; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = c;
        break;
      end
    end
    model_frame(xl, xr, dly, fb, mix, byp, el, er);
    chk("latency", lat, 4);
    chk("out_left", $signed(out_left), el);
    chk("out_right", $signed(out_right), er);
    ol  = $signed(out_left);
    orr = $signed(out_right);
    @(posedge clk);
    #1;
    chk("valid_pulse_width", out_valid, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int ol, orr, pulses, pl, pr, el, er;
    int imp_exp [4];
    int bx_l [6];
    int bx_r [6];
    imp_exp = '{16384, 16320, 8160, 4080};
    model_clear();

    apply_reset();

    // Impulse with delay 4, fb 128, mix 255
    for (int f = 0; f < 16; f++) begin
      send_frame((f == 0) ? 16384 : 0, 0, 4, 128, 255, 0, ol, orr);
      if (f % 4 == 0) begin
        chk("impulse_left", ol, imp_exp[f / 4]);
        chk("impulse_right", orr, 0);
      end
    end

    // Saturation positive then negative
    for (int f = 0; f < 12; f++) begin
      send_frame(30000, 30000, 1, 255, 255, 0, ol, orr);
      chk("sat_pos_nonneg", ol >= 0, 1);
    end
    chk("sat_pos_clamp", ol, 32767);
    chk("sat_pos_clamp_r", orr, 32767);
    for (int f = 0; f < 12; f++) begin
      send_frame(-30000, -30000, 1, 255, 255, 0, ol, orr);
    end
    chk("sat_neg_clamp", ol, -32768);
    chk("sat_neg_clamp_r", orr, -32768);

    // Bypass with random samples and controls, then echo of bypassed frames
    for (int f = 0; f < 6; f++) begin
      bx_l[f] = rnd_sample();
      bx_r[f] = rnd_sample();
      send_frame(bx_l[f], bx_r[f], int'($urandom_range(15, 0)), int'($urandom_range(255, 0)),
                 int'($urandom_range(255, 0)), 1, ol, orr);
      chk("bypass_left_exact", ol, bx_l[f]);
      chk("bypass_right_exact", orr, bx_r[f]);
    end
    for (int k = 0; k < 2; k++) begin
      send_frame(0, 0, 2, int'($urandom_range(255, 0)), 128, 0, ol, orr);
      chk("bypass_echo_left", ol, (bx_l[4 + k] * 128) >>> 8);
      chk("bypass_echo_right", orr, (bx_r[4 + k] * 128) >>> 8);
    end

    // Random frames against the reference model
    for (int f = 0; f < 20; f++) begin
      send_frame(rnd_sample(), rnd_sample(), int'($urandom_range(15, 0)),
                 int'($urandom_range(255, 0)), int'($urandom_range(255, 0)),
                 ($urandom_range(7, 0) == 0) ? 1 : 0, ol, orr);
    end

    // Overrun: second edge two cycles after the first
    @(negedge clk);
    in_left = 16'(1234); in_right = 16'(-4321);
    delay = AW'(3); fb_gain = 8'(100); mix_gain = 8'(200); bypass = 1'b0;
    in_rec_clk = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_rec_clk = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_rec_clk = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_rec_clk = 1'b0;
    pulses = 0; pl = 0; pr = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        pulses++;
        pl = $signed(out_left);
        pr = $signed(out_right);
      end
    end
    model_frame(1234, -4321, 3, 100, 200, 0, el, er);
    chk("overrun_pulses", pulses, 1);
    chk("overrun_frame_left", pl, el);
    chk("overrun_frame_right", pr, er);
    chk("overrun_set", overrun, 1);
    send_frame(500, -500, 1, 64, 64, 0, ol, orr);
    chk("overrun_sticky", overrun, 1);

    // Wrap with delay 0 (full depth)
    apply_reset();
    for (int f = 0; f < 40; f++) begin
      send_frame((f == 0) ? 16384 : 0, 0, 0, 128, 255, 0, ol, orr);
      if (f == 0)  chk("wrap_f0", ol, 16384);
      if (f == 15) chk("wrap_f15_quiet", ol, 0);
      if (f == 16) chk("wrap_f16_echo", ol, 16320);
      if (f == 32) chk("wrap_f32_echo", ol, 8160);
    end

    // Reset asserted while the frame is in MAC
    @(negedge clk);
    in_left = 16'(20000); in_right = 16'(-20000);
    delay = AW'(0); fb_gain = 8'(255); mix_gain = 8'(255); bypass = 1'b0;
    in_rec_clk = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_rec_clk = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_values();
    @(negedge clk);
    rst = 1'b0;
    wait_ready();
    send_frame(777, -777, 0, 255, 255, 0, ol, orr);
    chk("post_reset_no_echo_l", ol, 777);
    chk("post_reset_no_echo_r", orr, -777);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
